icache_dm_param: RTL and testbench

- Parametrised direct-mapped instruction cache; successor to the fixed 16-entry, single-word-line fetch cache.
- Sits between the fetch stage (send_pulse/ack request interface) and one wishbone-style read port to instruction memory.
- Supports configurable line count, multi-word lines, critical-word-first fill with early restart, and a flush input.

---
 rtl/icache_dm_param.sv | 254 +++++++++++++++++++++++++
 tb/tb_icache_dm_param.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm_param.sv
// icache_dm_param: parametrised direct-mapped instruction cache.
// Serves fetch requests with a zero-latency hit path. On a miss it fills the
// whole line from instruction memory, critical word first, and acks the
// requested word on the first returned beat (early restart).
//
// Optional feature macro: ICACHE_STATS_EN adds saturating hit/miss counters.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   addr                fetch byte address (bits [1:0] ignored)
//   send_pulse          one-cycle fetch request, accepted only while ready=1
//   flush               one-cycle request to invalidate every line
//   inst, ack           instruction and its one-cycle valid pulse
//   ready               cache can accept send_pulse this cycle
//   mem_req, mem_addr   one-cycle memory read request, word-aligned address
//   mem_rdata,mem_valid memory read data and its one-cycle valid pulse
//   mem_busy            memory cannot accept mem_req
//   hit_cnt, miss_cnt   (ICACHE_STATS_EN only) saturating event counters
module icache_dm_param #(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              send_pulse,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              ack,
    output logic              ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_valid,
    input  logic              mem_busy
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned WA_W   = ADDR_W - 2;
    localparam int unsigned LINE_W = WA_W - OFF_W;
    localparam int unsigned TAG_W  = LINE_W - IDX_W;
    localparam int unsigned PTR_W  = (OFF_W == 0) ? 1 : OFF_W;
    localparam int unsigned CNT_W  = OFF_W + 1;
    localparam int unsigned DA_W   = IDX_W + OFF_W;
    localparam int unsigned DEPTH  = NUM_LINES * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_n;

    // Request address decode; the byte offset within a word is not used.
    logic [WA_W-1:0]   word_addr;
    logic [LINE_W-1:0] req_line;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [PTR_W-1:0]  req_off;
    logic              unused_addr_bits;

    assign word_addr        = addr[ADDR_W-1:2];
    assign unused_addr_bits = ^addr[1:0];
    assign req_line         = LINE_W'(word_addr >> OFF_W);
    assign req_idx          = IDX_W'(req_line);
    assign req_tag          = TAG_W'(req_line >> IDX_W);
    // With single-word lines there is no offset; the pointer is pinned to 0.
    assign req_off          = (OFF_W == 0) ? '0 : PTR_W'(word_addr);

    // Line storage: valid bits are reset, tags and data are not.
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [DEPTH];

    // Flat data-array index of word ptr within line idx.
    function automatic logic [DA_W-1:0] data_index(input logic [IDX_W-1:0] idx,
                                                   input logic [PTR_W-1:0] ptr);
        logic [31:0] flat;
        flat = (32'(idx) << OFF_W) + ((OFF_W == 0) ? 32'd0 : 32'(ptr));
        return DA_W'(flat);
    endfunction

    logic        hit;
    logic [31:0] rd_word;

    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_word = data_mem[data_index(req_idx, req_off)];

    // Miss context held for the duration of the fill.
    logic [LINE_W-1:0] m_line;
    logic [PTR_W-1:0]  m_ptr;
    logic [CNT_W-1:0]  fill_cnt;
    logic [IDX_W-1:0]  m_idx;
    logic [TAG_W-1:0]  m_tag;
    logic [PTR_W-1:0]  ptr_next;
    logic [WA_W-1:0]   mem_word;
    logic              last_beat;

    assign m_idx     = IDX_W'(m_line);
    assign m_tag     = TAG_W'(m_line >> IDX_W);
    assign ptr_next  = (OFF_W == 0) ? '0 : m_ptr + PTR_W'(1);
    assign mem_word  = (WA_W'(m_line) << OFF_W) | WA_W'(m_ptr);
    assign last_beat = (fill_cnt == CNT_W'(WORDS_PER_LINE - 1));

    logic miss_start;
    logic fill_beat;
    logic line_done;
    logic flush_clr;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and combinational outputs.
    always_comb begin
        state_n    = state;
        ready      = 1'b0;
        ack        = 1'b0;
        inst       = '0;
        mem_req    = 1'b0;
        miss_start = 1'b0;
        fill_beat  = 1'b0;
        line_done  = 1'b0;
        flush_clr  = 1'b0;
        case (state)
            IDLE: begin
                ready = !flush;
                if (flush) begin
                    flush_clr = 1'b1;
                end else if (send_pulse) begin
                    if (hit) begin
                        ack  = 1'b1;
                        inst = rd_word;
                    end else begin
                        miss_start = 1'b1;
                        state_n    = REQ;
                    end
                end
            end
            REQ: begin
                if (flush) begin
                    flush_clr = 1'b1;
                    state_n   = IDLE;
                end else if (!mem_busy) begin
                    mem_req = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    // A beat landing with the flush completes the transaction now.
                    if (mem_valid) begin
                        flush_clr = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        state_n = DRAIN;
                    end
                end else if (mem_valid) begin
                    fill_beat = 1'b1;
                    if (fill_cnt == '0) begin
                        ack  = 1'b1;
                        inst = mem_rdata;
                    end
                    if (last_beat) begin
                        line_done = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            DRAIN: begin
                if (mem_valid) begin
                    flush_clr = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_addr = mem_req ? {mem_word, 2'b00} : '0;

    // Valid bits: flush clears all, a miss drops its line until fully refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_clr) begin
            valid <= '0;
        end else if (miss_start) begin
            valid[req_idx] <= 1'b0;
        end else if (line_done) begin
            valid[m_idx] <= 1'b1;
        end
    end

    // Fill bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_line   <= '0;
            m_ptr    <= '0;
            fill_cnt <= '0;
        end else if (miss_start) begin
            m_line   <= req_line;
            m_ptr    <= req_off;
            fill_cnt <= '0;
        end else if (fill_beat) begin
            m_ptr    <= ptr_next;
            fill_cnt <= fill_cnt + CNT_W'(1);
        end
    end

    // Tag and data arrays.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[data_index(m_idx, m_ptr)] <= mem_rdata;
        end
        if (line_done) begin
            tag_mem[m_idx] <= m_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (ack && (state == IDLE) && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_start && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm_param.sv
// tb_icache_dm_param: self-checking bench for icache_dm_param with a
// fixed-latency instruction memory and a line-level cache model.
`timescale 1ns/1ps
module tb_icache_dm_param;

    localparam int unsigned NL      = 16;
    localparam int unsigned WPL     = 4;
    localparam int unsigned AW      = 32;
    localparam int          MEM_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          send_pulse;
    logic          flush;
    logic [31:0]   inst;
    logic          ack;
    logic          ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic          mem_valid = 1'b0;
    logic          mem_busy;
`ifdef ICACHE_STATS_EN
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    icache_dm_param #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .send_pulse (send_pulse),
        .flush      (flush),
        .inst       (inst),
        .ack        (ack),
        .ready      (ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .mem_busy   (mem_busy)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: one request at a time, data MEM_LAT cycles later.
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    int          overlap_cnt = 0;

    always @(posedge clk) begin
        mem_valid <= 1'b0;
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                mem_valid <= 1'b1;
                mem_rdata <= mem_word(pend_addr);
                pend = 0;
            end
        end
        if (mem_req && !mem_busy) begin
            if (pend) overlap_cnt = overlap_cnt + 1;
            pend      = 1;
            pend_cnt  = MEM_LAT;
            pend_addr = mem_addr;
        end
    end

    // Record every ack and every memory request.
    logic [31:0] ack_q[$];
    logic [31:0] req_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (ack) ack_q.push_back(inst);
            if (mem_req) req_q.push_back(mem_addr);
        end
    end

    // Cache model: which memory line each index currently holds.
    bit          mv[NL];
    int unsigned mt[NL];
    int unsigned exp_hits = 0;
    int unsigned exp_misses = 0;

    task automatic model_clear();
        for (int i = 0; i < int'(NL); i++) mv[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int limit, output bit ok);
        int n;
        n = 0;
        while (!ready && n < limit) begin
            tick();
            n++;
        end
        ok = ready;
    endtask

    // One fetch, predicted from the model and checked end to end.
    task automatic do_access(input logic [31:0] a, input bit rand_busy);
        int unsigned line, idx, tg, off;
        bit exp_hit, ok;
        int n;
        logic [31:0] exp_a;
        line = (a >> 2) / WPL;
        idx  = line % NL;
        tg   = line / NL;
        off  = (a >> 2) % WPL;
        wait_ready(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL access_ready_wait addr=%h ready=%b required=1", a, ready);
            return;
        end
        ack_q.delete();
        req_q.delete();
        exp_hit = mv[idx] && (mt[idx] == tg);
        addr = a;
        send_pulse = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== exp_hit) begin
            errors++;
            $display("FAIL access_same_cycle_ack addr=%h ack=%b required=%b", a, ack, exp_hit);
        end
        if (exp_hit) begin
            checks++;
            if (inst !== mem_word(a)) begin
                errors++;
                $display("FAIL hit_inst addr=%h inst=%h required=%h", a, inst, mem_word(a));
            end
        end
        @(posedge clk);
        #1;
        send_pulse = 1'b0;
        addr = $urandom;
        if (exp_hit) begin
            exp_hits++;
            checks++;
            if (req_q.size() != 0) begin
                errors++;
                $display("FAIL hit_mem_req addr=%h reqs=%0d required=0", a, req_q.size());
            end
        end else begin
            exp_misses++;
            n = 0;
            while (!ready && n < 300) begin
                if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            mem_busy = 1'b0;
            checks++;
            if (!ready) begin
                errors++;
                $display("FAIL miss_ready_return addr=%h ready=%b required=1", a, ready);
            end
            checks++;
            if (ack_q.size() != 1) begin
                errors++;
                $display("FAIL miss_ack_count addr=%h acks=%0d required=1", a, ack_q.size());
            end else begin
                checks++;
                if (ack_q[0] !== mem_word(a)) begin
                    errors++;
                    $display("FAIL miss_inst addr=%h inst=%h required=%h", a, ack_q[0], mem_word(a));
                end
            end
            checks++;
            if (req_q.size() != WPL) begin
                errors++;
                $display("FAIL miss_req_count addr=%h reqs=%0d required=%0d", a, req_q.size(), WPL);
            end else begin
                for (int k = 0; k < int'(WPL); k++) begin
                    exp_a = 32'((line * WPL + (off + k) % WPL) * 4);
                    checks++;
                    if (req_q[k] !== exp_a) begin
                        errors++;
                        $display("FAIL miss_mem_addr beat=%0d got=%h required=%h", k, req_q[k], exp_a);
                    end
                end
            end
            mv[idx] = 1;
            mt[idx] = tg;
        end
    endtask

    // Flush while idle, optionally with a coincident (losing) send_pulse.
    task automatic flush_idle(input bit with_req);
        bit ok;
        wait_ready(200, ok);
        addr = 32'h40;
        send_pulse = with_req;
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || ack !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle ready=%b ack=%b mem_req=%b required=0,0,0 ok=%b", ready, ack, mem_req, ok);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        send_pulse = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = '0;
        send_pulse = 1'b0;
        flush = 1'b0;
        mem_busy = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ack !== 1'b0 || inst !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs ack=%b inst=%h mem_req=%b mem_addr=%h ready=%b required=0,0,0,0,1",
                     ack, inst, mem_req, mem_addr, ready);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats hit=%0d miss=%0d required=0,0", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_cold_miss();
        logic [31:0] exp_seq[4];
        exp_seq[0] = 32'h48;
        exp_seq[1] = 32'h4C;
        exp_seq[2] = 32'h40;
        exp_seq[3] = 32'h44;
        do_access(32'h48, 1'b0);
        checks++;
        if (req_q.size() != 4) begin
            errors++;
            $display("FAIL cold_req_count got=%0d required=4", req_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (req_q[k] !== exp_seq[k]) begin
                    errors++;
                    $display("FAIL cold_mem_addr beat=%0d got=%h required=%h", k, req_q[k], exp_seq[k]);
                end
            end
        end
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 32'hA5A5_0012) begin
            errors++;
            $display("FAIL cold_ack acks=%0d required=1 inst=%h required=a5a50012",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 32'h0);
        end
    endtask

    task automatic test_hit();
        do_access(32'h40, 1'b0);
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== 32'hA5A5_0010) begin
            errors++;
            $display("FAIL hit_0x40 acks=%0d required=1 inst=%h required=a5a50010",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 32'h0);
        end
    endtask

    task automatic test_conflict();
        do_access(32'h148, 1'b0);
        do_access(32'h48, 1'b0);
        checks++;
        if (req_q.size() != 4) begin
            errors++;
            $display("FAIL conflict_refetch reqs=%0d required=4", req_q.size());
        end
    endtask

    task automatic test_flush_mid_fill();
        bit ok;
        wait_ready(200, ok);
        ack_q.delete();
        req_q.delete();
        addr = 32'h80;
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        exp_misses++;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ready(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flush_drain_ready ready=%b required=1", ready);
        end
        checks++;
        if (pend) begin
            errors++;
            $display("FAIL flush_drain_consumed pending=%b required=0", pend);
        end
        repeat (6) tick();
        checks++;
        if (ack_q.size() != 0 || req_q.size() != 1) begin
            errors++;
            $display("FAIL flush_mid_fill acks=%0d required=0 reqs=%0d required=1", ack_q.size(), req_q.size());
        end
        model_clear();
        do_access(32'h80, 1'b0);
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        wait_ready(200, ok);
        ack_q.delete();
        req_q.delete();
        mem_busy = 1'b1;
        addr = 32'h200;
        send_pulse = 1'b1;
        tick();
        exp_misses++;
        for (int i = 0; i < 5; i++) begin
            addr = 32'h80;
            send_pulse = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || ack !== 1'b0 || ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold cycle=%0d mem_req=%b ack=%b ready=%b required=0,0,0", i, mem_req, ack, ready);
            end
            @(posedge clk);
            #1;
        end
        send_pulse = 1'b0;
        mem_busy = 1'b0;
        n = 0;
        while (!ready && n < 100) begin
            send_pulse = $urandom_range(0, 1) == 1;
            @(negedge clk);
            @(posedge clk);
            #1;
            send_pulse = 1'b0;
            n++;
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("FAIL busy_ready_return ready=%b required=1", ready);
        end
        checks++;
        if (ack_q.size() != 1 || ack_q[0] !== mem_word(32'h200)) begin
            errors++;
            $display("FAIL busy_ack acks=%0d required=1 inst=%h required=%h",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : 32'h0, mem_word(32'h200));
        end
        checks++;
        if (req_q.size() != WPL || req_q[0] !== 32'h200) begin
            errors++;
            $display("FAIL busy_reqs reqs=%0d required=%0d first=%h required=00000200",
                     req_q.size(), WPL, (req_q.size() > 0) ? req_q[0] : 32'h0);
        end
        mv[0] = 1;
        mt[0] = 2;
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) flush_idle($urandom_range(0, 1) == 1);
            a = 32'(((($urandom_range(0, 3) * NL) + $urandom_range(0, NL - 1)) * WPL
                     + $urandom_range(0, WPL - 1)) * 4 + $urandom_range(0, 3));
            do_access(a, 1'b1);
        end
    endtask

    task automatic test_stats();
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL stats_counts hit=%0d required=%0d miss=%0d required=%0d",
                     hit_cnt, exp_hits, miss_cnt, exp_misses);
        end
`endif
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL one_outstanding overlaps=%0d required=0", overlap_cnt);
        end
    endtask

    task automatic test_reset_mid_fill();
        flush_idle(1'b0);
        addr = 32'h48;
        send_pulse = 1'b1;
        tick();
        send_pulse = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_fill ack=%b ready=%b mem_req=%b mem_addr=%h required=0,1,0,0",
                     ack, ready, mem_req, mem_addr);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_fill_stats hit=%0d miss=%0d required=0,0", hit_cnt, miss_cnt);
        end
`endif
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        ack_q.delete();
        repeat (8) tick();
        checks++;
        if (ack_q.size() != 0) begin
            errors++;
            $display("FAIL stale_beat_ignored acks=%0d required=0", ack_q.size());
        end
        do_access(32'h48, 1'b0);
        test_stats();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_mid_fill();
        test_backpressure();
        test_random();
        test_stats();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
